// File: rtl/fft_pkg.sv
// Shared constants for the FFT butterfly stage: Q1.14 twiddles for W_16^m and a
// saturation helper. Rounding behaviour elsewhere is selected by FFT_STAGE_PIPE_ROUND_EN.
package fft_pkg;

    localparam int TW_FRAC = 14;

    // W_16^m = cos(2*pi*m/16) - j*sin(2*pi*m/16); sin stored positive, sign applied in the multiply
    localparam logic signed [15:0] TW_COS [0:7] = '{
        16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270,
        16'sd0, -16'sd6270, -16'sd11585, -16'sd15137
    };
    localparam logic signed [15:0] TW_SIN [0:7] = '{
        16'sd0, 16'sd6270, 16'sd11585, 16'sd15137,
        16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270
    };

    function automatic logic signed [31:0] sat_w(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/fft_cmul_pipe.sv
// Registered complex multiply of b by a fixed twiddle W_16^TW_IDX, result W+1 bits.
// FFT_STAGE_PIPE_ROUND_EN selects round-half-up instead of truncation.
module fft_cmul_pipe
    import fft_pkg::*;
#(
    parameter int W      = 8,
    parameter int TW_IDX = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    output logic signed [W:0]   t_re,
    output logic signed [W:0]   t_im
);

    localparam int PW = W + 17;
    localparam logic signed [PW-1:0] C = PW'(TW_COS[TW_IDX]);
    localparam logic signed [PW-1:0] S = PW'(TW_SIN[TW_IDX]);

    logic signed [PW-1:0] p_re, p_im, r_re, r_im;
    logic unused_bits;

    // (br + j*bi) * (c - j*s)
    assign p_re = PW'(b_re) * C + PW'(b_im) * S;
    assign p_im = PW'(b_im) * C - PW'(b_re) * S;

`ifdef FFT_STAGE_PIPE_ROUND_EN
    localparam logic signed [PW-1:0] BIAS = PW'(1) <<< (TW_FRAC - 1);
    assign r_re = p_re + BIAS;
    assign r_im = p_im + BIAS;
`else
    assign r_re = p_re;
    assign r_im = p_im;
`endif

    assign unused_bits = ^{r_re[PW-1:TW_FRAC+W+1], r_re[TW_FRAC-1:0],
                           r_im[PW-1:TW_FRAC+W+1], r_im[TW_FRAC-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            t_re <= '0;
            t_im <= '0;
        end else if (en) begin
            t_re <= r_re[TW_FRAC +: W+1];
            t_im <= r_im[TW_FRAC +: W+1];
        end
    end

endmodule

// File: rtl/fft_stage_pipe.sv
// Two-stage radix-2 DIT butterfly over a parallel 2**LOG_PTS frame with valid/ready
// backpressure, optional 1/2 scaling and sticky saturation. Rounding: FFT_STAGE_PIPE_ROUND_EN.
module fft_stage_pipe
    import fft_pkg::*;
#(
    parameter int W       = 8,
    parameter int LOG_PTS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W*(2**LOG_PTS)-1:0] in_r,
    input  logic [W*(2**LOG_PTS)-1:0] in_i,
    input  logic                      scale,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W*(2**LOG_PTS)-1:0] out_r,
    output logic [W*(2**LOG_PTS)-1:0] out_i,
    input  logic                      clear_sat,
    output logic                      sat_sticky
);

    localparam int P       = 2**LOG_PTS;
    localparam int H       = P / 2;
    localparam int TW_STEP = 16 / P;
    localparam int XW      = W + 2;

    logic [2:1]          vld_pipe;
    logic                ld2, acc, st2_load, sc1, sat_any;
    logic [H-1:0][W-1:0] a_re, a_im;
    logic [H-1:0][W:0]   tw_re, tw_im;
    logic [P-1:0][W-1:0] res_re, res_im, nxt_re, nxt_im;

    assign ld2       = !vld_pipe[2] || out_ready;
    assign in_ready  = !vld_pipe[1] || ld2;
    assign acc       = in_valid && in_ready;
    assign st2_load  = ld2 && vld_pipe[1];
    assign out_valid = vld_pipe[2];
    assign out_r     = res_re;
    assign out_i     = res_im;

    for (genvar k = 0; k < H; k++) begin : g_pair
        fft_cmul_pipe #(.W(W), .TW_IDX(k * TW_STEP)) u_cmul (
            .clk  (clk),
            .rst  (rst),
            .en   (acc),
            .b_re (in_r[(k+H)*W +: W]),
            .b_im (in_i[(k+H)*W +: W]),
            .t_re (tw_re[k]),
            .t_im (tw_im[k])
        );
    end

    function automatic logic signed [XW-1:0] halve(input logic signed [XW-1:0] x);
`ifdef FFT_STAGE_PIPE_ROUND_EN
        return (x + XW'(1)) >>> 1;
`else
        return x >>> 1;
`endif
    endfunction

    // Returns {saturated, value} for a +/- t, optionally halved.
    function automatic logic [W:0] post(input logic [W-1:0] a, input logic [W:0] t,
                                        input logic neg, input logic sc);
        logic signed [XW-1:0] x;
        logic signed [31:0]   z;
        x = neg ? XW'($signed(a)) - XW'($signed(t)) : XW'($signed(a)) + XW'($signed(t));
        if (sc) x = halve(x);
        z = sat_w(32'(x), W);
        return {z != 32'(x), z[W-1:0]};
    endfunction

    always_comb begin
        logic [W:0] q;
        q       = '0;
        nxt_re  = '0;
        nxt_im  = '0;
        sat_any = 1'b0;
        for (int k = 0; k < H; k++) begin
            q = post(a_re[k], tw_re[k], 1'b0, sc1); nxt_re[k]   = q[W-1:0]; sat_any = sat_any | q[W];
            q = post(a_im[k], tw_im[k], 1'b0, sc1); nxt_im[k]   = q[W-1:0]; sat_any = sat_any | q[W];
            q = post(a_re[k], tw_re[k], 1'b1, sc1); nxt_re[k+H] = q[W-1:0]; sat_any = sat_any | q[W];
            q = post(a_im[k], tw_im[k], 1'b1, sc1); nxt_im[k+H] = q[W-1:0]; sat_any = sat_any | q[W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            a_re       <= '0;
            a_im       <= '0;
            sc1        <= 1'b0;
            res_re     <= '0;
            res_im     <= '0;
            sat_sticky <= 1'b0;
        end else begin
            if (in_ready) vld_pipe[1] <= in_valid;
            if (ld2)      vld_pipe[2] <= vld_pipe[1];
            if (acc) begin
                for (int k = 0; k < H; k++) begin
                    a_re[k] <= in_r[k*W +: W];
                    a_im[k] <= in_i[k*W +: W];
                end
                sc1 <= scale;
            end
            if (st2_load) begin
                res_re <= nxt_re;
                res_im <= nxt_im;
            end
            // a fresh saturation event beats a simultaneous clear
            if (st2_load && sat_any) sat_sticky <= 1'b1;
            else if (clear_sat)      sat_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_stage_pipe.sv
// Directed, table-driven bench for fft_stage_pipe (W=8, 8 points) plus handshake sequences.
module tb_fft_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, scale, out_valid, out_ready, clear_sat, sat_sticky;
    logic [63:0] in_r, in_i, out_r, out_i;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FFT_STAGE_PIPE_ROUND_EN
    localparam int K1_I = -45, SC_S = 2, SC_D = -1;
`else
    localparam int K1_I = -46, SC_S = 1, SC_D = -2;
`endif

    typedef struct {
        logic [63:0] ir, ii;
        logic        sc;
        logic [63:0] er, ei;
        logic        es;
    } vec_t;

    vec_t vecs [7];

    fft_stage_pipe #(.W(8), .LOG_PTS(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .scale(scale), .out_valid(out_valid),
        .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
        .clear_sat(clear_sat), .sat_sticky(sat_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [63:0] pt(input int p, input int v);
        logic [63:0] r;
        r = '0;
        r[p*8 +: 8] = v[7:0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk); clear_sat = 1'b1;
        @(negedge clk); clear_sat = 1'b0;
        in_r = v.ir; in_i = v.ii; scale = v.sc; in_valid = 1'b1;
        #1 chk($sformatf("vec%0d in_ready", idx), 64'(in_ready), 64'd1);
        n = 0;
        do begin
            @(negedge clk); in_valid = 1'b0; n++; #1;
        end while (!out_valid && n < 10);
        chk($sformatf("vec%0d latency", idx), 64'(n), 64'd2);
        chk($sformatf("vec%0d out_r", idx), out_r, v.er);
        chk($sformatf("vec%0d out_i", idx), out_i, v.ei);
        chk($sformatf("vec%0d sat", idx), 64'(sat_sticky), 64'(v.es));
    endtask

    initial begin
        int          tag, got, stall_acc, cnt;
        logic        stalled;
        logic [63:0] held_r;

        vecs[0] = '{ir: pt(0,10) | pt(4,4), ii: '0, sc: 1'b0,
                    er: pt(0,14) | pt(4,6), ei: '0, es: 1'b0};
        vecs[1] = '{ir: pt(2,20) | pt(6,10), ii: '0, sc: 1'b0,
                    er: pt(2,20) | pt(6,20), ei: pt(2,-10) | pt(6,10), es: 1'b0};
        vecs[2] = '{ir: pt(0,100) | pt(4,100), ii: '0, sc: 1'b0,
                    er: pt(0,127), ei: '0, es: 1'b1};
        vecs[3] = '{ir: pt(0,100) | pt(4,100), ii: '0, sc: 1'b1,
                    er: pt(0,100), ei: '0, es: 1'b0};
        vecs[4] = '{ir: pt(5,64), ii: '0, sc: 1'b0,
                    er: pt(1,45) | pt(5,-45), ei: pt(1,K1_I) | pt(5,-K1_I), es: 1'b0};
        vecs[5] = '{ir: pt(4,3), ii: '0, sc: 1'b1,
                    er: pt(0,SC_S) | pt(4,SC_D), ei: '0, es: 1'b0};
        vecs[6] = '{ir: pt(0,-100) | pt(4,100), ii: pt(0,-128) | pt(4,-128), sc: 1'b0,
                    er: pt(4,-128), ei: pt(0,-128), es: 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_r = '0; in_i = '0; scale = 1'b0;
        out_ready = 1'b1; clear_sat = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset sat", 64'(sat_sticky), 64'd0);
        chk("reset out_r", out_r, 64'd0);
        chk("reset out_i", out_i, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // saturation in the same cycle as clear_sat: the set must win
        @(negedge clk); clear_sat = 1'b1;
        in_r = vecs[2].ir; in_i = '0; scale = 1'b0; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #1;
        chk("set beats clear", 64'(sat_sticky), 64'd1);
        @(negedge clk); #1;
        chk("clear after", 64'(sat_sticky), 64'd0);
        clear_sat = 1'b0;

        // backpressure: 4 back-to-back frames, out_ready low for 3 cycles
        tag = 1; got = 0; stall_acc = 0; stalled = 1'b0; held_r = '0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            in_valid  = (tag <= 4);
            in_r      = pt(0, tag);
            in_i      = '0;
            #1;
            if (stalled) begin
                chk("stall hold out_r", out_r, held_r);
                chk("stall hold valid", 64'(out_valid), 64'd1);
            end
            if (cyc == 2) chk("in_ready both full", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                got++;
                chk($sformatf("order frame %0d", got), out_r, pt(0, got) | pt(4, got));
            end
            stalled = out_valid && !out_ready;
            held_r  = out_r;
            if (in_valid && in_ready) begin
                if (cyc < 3) stall_acc++;
                tag++;
            end
        end
        @(negedge clk); in_valid = 1'b0;
        chk("accepted during stall", 64'(stall_acc), 64'd2);
        chk("frames received", 64'(got), 64'd4);
        cnt = 0;
        repeat (4) begin @(negedge clk); #1; if (out_valid) cnt++; end
        chk("no duplicate frames", 64'(cnt), 64'd0);

        // reset with both stages full: those frames must vanish
        out_ready = 1'b0;
        @(negedge clk); in_r = pt(0, 7); in_valid = 1'b1;
        @(negedge clk); in_r = pt(0, 8);
        @(negedge clk); in_valid = 1'b0; #1;
        chk("pre-reset full", 64'({out_valid, in_ready}), 64'b10);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset in_ready", 64'(in_ready), 64'd1);
        chk("midreset out_r", out_r, 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        cnt = 0;
        repeat (6) begin @(negedge clk); #1; if (out_valid) cnt++; end
        chk("flushed frames absent", 64'(cnt), 64'd0);

        run_vec(vecs[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_stage_pipe.md
Name: fft_stage_pipe

Overview:
- Pipelined, parametrised radix-2 DIT butterfly stage over a 2**LOG_PTS-point frame presented in parallel (real/imag vectors).
- Pairs are point k and point k+P/2, for k = 0..P/2-1, where P = 2**LOG_PTS. The butterfly computes a ± W_P^k·b.
- Successor to the combinational final-stage block. Adds selectable data width and point count, a twiddle multiply, per-frame 1/2 scaling, saturation with a sticky flag, and a two-stage valid/ready pipeline with backpressure.
- Sits as the last stage of the FFT datapath, feeding the output formatter.

Parameters:
- W, 8, signed two's-complement sample width (real and imag each); legal 4..24.
- LOG_PTS, 3, log2 of frame size; legal 1..4 (2..16 points).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input frame valid.
- in_ready  out  1  stage can accept a frame this cycle.
- in_r  in  W*2**LOG_PTS  real parts; point n at bits [n*W +: W].
- in_i  in  W*2**LOG_PTS  imag parts; same packing as in_r.
- scale  in  1  1 = divide butterfly outputs by 2; sampled with the frame.
- out_valid  out  1  output frame valid.
- out_ready  in  1  downstream accepts the frame.
- out_r  out  W*2**LOG_PTS  real results; same packing as in_r.
- out_i  out  W*2**LOG_PTS  imag results; same packing as in_r.
- clear_sat  in  1  clears sat_sticky.
- sat_sticky  out  1  set when any output component saturated since the last clear.

Behaviour:
- Reset (synchronous, takes priority over all other activity):
  - Both pipeline valids go to 0, so out_valid=0 and in_ready=1 on the next cycle.
  - sat_sticky=0 and out_r=out_i=0.
  - Frames in flight are discarded.
- Stage 1, accept:
  - A frame is accepted when in_valid && in_ready.
  - The b operand (point k+P/2) is multiplied by the twiddle for index k at scale P: complex product, full precision.
  - Rounding: add 2**(TW_FRAC-1), then arithmetic shift right by TW_FRAC, giving W+1 bits.
  - The a operand and the scale bit are registered alongside the product.
- Stage 2:
  - sum = a + tb and diff = a - tb, computed at W+2 bits.
  - If scale=1: value = (x + 1) >>> 1, arithmetic.
  - Each component is then saturated to [-2**(W-1), 2**(W-1)-1].
  - Results are registered to out_*; sum goes to point k, diff to point k+P/2.
- Handshake:
  - Stage 2 is able to load when it is empty or out_ready=1.
  - in_ready = !v1 || (stage 2 able to load). This is combinational from out_ready; there is no skid buffer.
  - Latency: 2 cycles from accept to out_valid with out_ready held high. Throughput: 1 frame/cycle.
  - out_* and out_valid hold stable while out_valid && !out_ready.
  - No frame is dropped or duplicated; frame order is preserved.
- Saturation flag:
  - sat_sticky is set in the cycle a saturating frame loads stage 2.
  - clear_sat clears it. If clear_sat and a new saturation event occur in the same cycle, set wins.
- Twiddle 0 is exactly 1: the product path is bit-exact passthrough of b.

Optional Feature:
- Macro: FFT_STAGE_PIPE_ROUND_EN.
- Defined: twiddle-product rounding and the scale divide use round-half-up, as described under Behaviour.
- Undefined: both use plain truncation (arithmetic shift, no bias added). This saves adders.
- Handshake, latency and saturation are identical in both builds.

Decomposition:
- Package fft_pkg holds:
  - TW_FRAC = 14.
  - TW_COS[0..7] and TW_SIN[0..7]: W_16^m in signed Q1.14, for example cos(pi/4) = 11585. Index for scale P at index k is k*(16/P).
  - Function sat_w(x, W).
- Sub-module fft_cmul_pipe: one registered complex multiply with rounding, instanced per butterfly pair via generate.
- The top level owns the handshake, the butterfly add/scale/saturate stage and the sticky flag.

Test Plan (W=8, LOG_PTS=3, out_ready=1 unless stated):
- Reset: hold rst 2 cycles -> out_valid=0, in_ready=1, sat_sticky=0, out_r/out_i all 0.
- Twiddle-0 pair: in_r[0]=10, in_r[4]=4, all others 0, scale=0 -> out_valid exactly 2 cycles after accept; out_r[0]=14, out_r[4]=6; all else 0.
- Twiddle k=2 (-j): in_r[2]=20, in_r[6]=10 -> out_r[2]=20, out_i[2]=-10, out_r[6]=20, out_i[6]=10.
- Saturation and scale:
  - in_r[0]=100, in_r[4]=100, scale=0 -> out_r[0]=127, out_r[4]=0, sat_sticky=1.
  - Pulse clear_sat, then resend with scale=1 -> out_r[0]=100, sat_sticky stays 0.
- Backpressure: 4 back-to-back frames tagged in_r[0]=1..4, out_ready=0 for 3 cycles.
  - Only 2 frames accepted during the stall; in_ready=0 while both stages are full.
  - Outputs appear in order 1,2,3,4 with no loss or duplicates.
  - out_* stay stable while stalled.
- Reset mid-stream: assert rst while both stages are valid -> next cycle out_valid=0; those frames never appear at the output.
